spi_frame_scheduler: RTL and testbench

SPI_FRAME_SCHEDULER -- requirements
Module: spi_frame_scheduler

---
 rtl/spi_frame_scheduler_pkg.sv | 16 +
 rtl/period_timer.sv | 36 +++
 rtl/spi_frame_scheduler.sv | 130 +++++++++++++
 tb/tb_spi_frame_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_scheduler_pkg.sv
// Shared types for the SPI frame scheduler: FSM state encoding and motor index width.
package spi_frame_scheduler_pkg;
  localparam int MOTOR_IDX_W = 8;

  typedef logic [MOTOR_IDX_W-1:0] motor_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_START,
    S_WAIT_DONE,
    S_LATCH,
    S_PID,
    S_GAP
  } state_t;
endpackage

// File: rtl/period_timer.sv
// Cycle period counter with a single-entry pending trigger for overruns.
module period_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] period_cycles,
  input  logic        load,
  input  logic        busy,
  input  logic        clear_pending,
  output logic        trigger,
  output logic        overrun
);
  logic [31:0] count;
  logic        timed;
  logic        pending;

  // Counter saturates at 0 so an expired period stays visible until the next cycle start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      timed   <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        count <= (period_cycles == 32'd0) ? 32'd0 : period_cycles - 32'd1;
        timed <= (period_cycles != 32'd0);
      end else if (count != 32'd0) begin
        count <= count - 32'd1;
      end
      if (load || clear_pending) pending <= 1'b0;
      else if (overrun)          pending <= 1'b1;
    end
  end

  assign overrun = busy && timed && (count == 32'd0);
  assign trigger = (period_cycles == 32'd0) || (count == 32'd0) || pending;
endmodule

// File: rtl/spi_frame_scheduler.sv
// Round-robin SPI frame scheduler for motors sharing one bus, with latch/PID sequencing.
module spi_frame_scheduler
  import spi_frame_scheduler_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        spi_enable,
  input  logic [NUMBER_OF_MOTORS-1:0] enable_mask,
  input  logic [31:0]                 period_cycles,
  input  logic                        clear_errors,
  output logic                        frame_start,
  input  logic                        frame_done,
  output logic [MOTOR_IDX_W-1:0]      motor_sel,
  output logic [NUMBER_OF_MOTORS-1:0] ss_sel,
  output logic                        latch_strobe,
  output logic                        pid_update,
  output logic [MOTOR_IDX_W-1:0]      pid_index,
  output logic                        busy,
  output logic                        overrun_err,
  output logic                        timeout_err,
  output logic [MOTOR_IDX_W-1:0]      timeout_motor,
  output logic [31:0]                 cycle_count
);
  localparam motor_idx_t                  LAST   = MOTOR_IDX_W'(NUMBER_OF_MOTORS);
  localparam logic [31:0]                 TO_END = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [NUMBER_OF_MOTORS-1:0] ONE    = NUMBER_OF_MOTORS'(1);

  state_t                      state, state_next;
  logic [NUMBER_OF_MOTORS-1:0] mask_lat;
  logic [255:0]                mask_ext;
  logic [31:0]                 tcount;
  logic                        stop_req, stop_now;
  logic                        trigger, overrun, cycle_start;
  logic                        scan_end, mask_hit, timed_out, timeout_hit;

  assign mask_ext    = 256'(mask_lat);
  assign scan_end    = (motor_sel >= LAST);
  assign mask_hit    = mask_ext[motor_sel];
  assign timed_out   = (tcount == TO_END);
  assign cycle_start = (state == S_IDLE) && spi_enable && trigger;
  assign timeout_hit = (state == S_WAIT_DONE) && !frame_done && timed_out;
  // A dropped enable is remembered so the cycle still winds down if it is re-raised.
  assign stop_now    = stop_req || (busy && !spi_enable);

  period_timer u_timer (
    .clock         (clock),
    .reset         (reset),
    .period_cycles (period_cycles),
    .load          (cycle_start),
    .busy          (busy),
    .clear_pending (stop_now),
    .trigger       (trigger),
    .overrun       (overrun)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (cycle_start) state_next = S_SCAN;
      S_SCAN:      if (stop_now || scan_end) state_next = S_IDLE;
                   else if (mask_hit)        state_next = S_START;
      S_START:     state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (frame_done)     state_next = S_LATCH;
                   else if (timed_out) state_next = S_GAP;
      S_LATCH:     state_next = S_PID;
      S_PID:       state_next = stop_now ? S_IDLE : S_GAP;
      S_GAP:       state_next = stop_now ? S_IDLE : S_SCAN;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    frame_start  = 1'b0;
    latch_strobe = 1'b0;
    pid_update   = 1'b0;
    ss_sel       = '0;
    busy         = (state != S_IDLE);
    case (state)
      S_START:     begin frame_start  = 1'b1; ss_sel = ONE << motor_sel; end
      S_WAIT_DONE: ss_sel = ONE << motor_sel;
      S_LATCH:     begin latch_strobe = 1'b1; ss_sel = ONE << motor_sel; end
      S_PID:       pid_update = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      motor_sel     <= '0;
      pid_index     <= '0;
      timeout_motor <= '0;
      cycle_count   <= '0;
      mask_lat      <= '0;
      tcount        <= '0;
      stop_req      <= 1'b0;
      overrun_err   <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cycle_start) begin
          mask_lat  <= enable_mask;
          motor_sel <= '0;
        end
        S_SCAN: if (!stop_now) begin
          if (scan_end)       cycle_count <= cycle_count + 32'd1;
          else if (!mask_hit) motor_sel   <= motor_sel + 8'd1;
        end
        S_START:     tcount    <= '0;
        S_WAIT_DONE: tcount    <= tcount + 32'd1;
        S_LATCH:     pid_index <= motor_sel;
        S_GAP:       if (!stop_now) motor_sel <= motor_sel + 8'd1;
        default:     ;
      endcase
      if (cycle_start)            stop_req <= 1'b0;
      else if (busy && !spi_enable) stop_req <= 1'b1;
      if (timeout_hit) timeout_motor <= motor_sel;
      // A new error event wins over a simultaneous clear.
      timeout_err <= timeout_hit || (timeout_err && !clear_errors);
      overrun_err <= overrun     || (overrun_err && !clear_errors);
    end
  end
endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Directed bench for spi_frame_scheduler: six motors, a scripted frame engine and logging monitors.
module tb_spi_frame_scheduler;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        spi_enable = 1'b0;
  logic [5:0]  enable_mask = '0;
  logic [31:0] period_cycles = '0;
  logic        clear_errors = 1'b0;
  logic        frame_done = 1'b0;
  logic        frame_start, latch_strobe, pid_update, busy, overrun_err, timeout_err;
  logic [7:0]  motor_sel, pid_index, timeout_motor;
  logic [5:0]  ss_sel;
  logic [31:0] cycle_count;

  spi_frame_scheduler #(.NUMBER_OF_MOTORS(6), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .spi_enable(spi_enable), .enable_mask(enable_mask),
    .period_cycles(period_cycles), .clear_errors(clear_errors), .frame_start(frame_start),
    .frame_done(frame_done), .motor_sel(motor_sel), .ss_sel(ss_sel), .latch_strobe(latch_strobe),
    .pid_update(pid_update), .pid_index(pid_index), .busy(busy), .overrun_err(overrun_err),
    .timeout_err(timeout_err), .timeout_motor(timeout_motor), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;
  int done_delay = 10;
  bit mute_en = 1'b0;
  int mute_motor = 0;
  int fs_log[$], lat_log[$], pid_log[$], rise_log[$];
  int ss_bad = 0, pid_gap_bad = 0, clk_n = 0;
  logic [5:0] ss_or = '0;
  bit prev_latch = 1'b0, prev_busy = 1'b0;

  always @(posedge clock) clk_n <= clk_n + 1;

  // Monitor: logs pulses by motor and flags illegal select / PID spacing.
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_start) fs_log.push_back(int'(motor_sel));
      if (latch_strobe) lat_log.push_back(int'(motor_sel));
      if (pid_update) begin
        pid_log.push_back(int'(pid_index));
        if (!prev_latch) pid_gap_bad++;
      end
      if (ss_sel !== 6'd0 && ss_sel !== (6'd1 << motor_sel)) ss_bad++;
      if (frame_start && ss_sel === 6'd0) ss_bad++;
      ss_or = ss_or | ss_sel;
      if (busy && !prev_busy) rise_log.push_back(clk_n);
      prev_latch = latch_strobe;
      prev_busy  = busy;
    end
  end

  // Frame engine model: answers done_delay clocks after each frame_start unless muted.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && frame_start && !(mute_en && motor_sel == 8'(mute_motor))) begin
        repeat (done_delay - 1) @(negedge clock);
        frame_done = 1'b1;
        @(negedge clock);
        frame_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  function automatic logic [63:0] enc(input int q[$]);
    logic [63:0] c = 64'hF;
    foreach (q[i]) c = (c << 4) | 64'(q[i] & 15);
    return c;
  endfunction

  task automatic clear_logs();
    fs_log.delete(); lat_log.delete(); pid_log.delete(); rise_log.delete();
    ss_bad = 0; pid_gap_bad = 0; ss_or = '0; prev_latch = 1'b0; prev_busy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; spi_enable = 1'b0; clear_errors = 1'b0; enable_mask = '0;
    period_cycles = '0; mute_en = 1'b0; done_delay = 10;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    clear_logs();
    @(negedge clock);
  endtask

  task automatic wait_count(input logic [31:0] tgt, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (cycle_count == tgt) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (fs_log.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({frame_start, latch_strobe, pid_update, busy, overrun_err, timeout_err} !== 6'd0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000",
        {frame_start, latch_strobe, pid_update, busy, overrun_err, timeout_err});
    end
    n_cmp++;
    if (ss_sel !== 6'd0) begin n_bad++; $display("FAIL reset_ss_sel: got %b want 0", ss_sel); end
    n_cmp++;
    if ({motor_sel, pid_index, timeout_motor} !== 24'd0) begin
      n_bad++; $display("FAIL reset_indices: got %h want 0", {motor_sel, pid_index, timeout_motor});
    end
    n_cmp++;
    if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL reset_cycle_count: got %0d want 0", cycle_count); end
  endtask

  task automatic test_full_mask();
    bit ok;
    do_reset();
    enable_mask = 6'b111111;
    spi_enable = 1'b1;
    wait_count(32'd2, 1000, ok);
    spi_enable = 1'b0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL full_cycles: cycle_count %0d want 2", cycle_count); end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (enc(fs_log) !== 64'hF012345012345) begin
      n_bad++; $display("FAIL full_frame_order: got %h want F012345012345", enc(fs_log));
    end
    n_cmp++;
    if (enc(pid_log) !== 64'hF012345012345) begin
      n_bad++; $display("FAIL full_pid_order: got %h want F012345012345", enc(pid_log));
    end
    n_cmp++;
    if (pid_gap_bad != 0 || lat_log.size() != 12) begin
      n_bad++; $display("FAIL full_pid_after_latch: bad=%0d latches=%0d want 0/12", pid_gap_bad, lat_log.size());
    end
    n_cmp++;
    if (busy !== 1'b0 || cycle_count !== 32'd2) begin
      n_bad++; $display("FAIL full_stop_idle: busy=%b count=%0d want 0/2", busy, cycle_count);
    end
  endtask

  task automatic test_sparse_mask();
    bit ok;
    do_reset();
    enable_mask = 6'b100101;
    spi_enable = 1'b1;
    wait_count(32'd1, 1000, ok);
    spi_enable = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (!ok || enc(fs_log) !== 64'hF025) begin
      n_bad++; $display("FAIL sparse_frames: got %h want F025 (ok=%b)", enc(fs_log), ok);
    end
    n_cmp++;
    if (ss_or !== 6'b100101 || ss_bad != 0) begin
      n_bad++; $display("FAIL sparse_ss_sel: or=%b bad=%0d want 100101/0", ss_or, ss_bad);
    end
  endtask

  task automatic test_period();
    bit ok;
    do_reset();
    enable_mask = 6'b111111;
    period_cycles = 32'd200;
    spi_enable = 1'b1;
    wait_count(32'd2, 1000, ok);
    spi_enable = 1'b0;
    n_cmp++;
    if (!ok || rise_log.size() != 2) begin
      n_bad++; $display("FAIL period_cycles_seen: starts=%0d want 2 (ok=%b)", rise_log.size(), ok);
    end else begin
      n_cmp++;
      if (rise_log[1] - rise_log[0] != 200) begin
        n_bad++; $display("FAIL period_spacing: got %0d want 200", rise_log[1] - rise_log[0]);
      end
    end
    n_cmp++;
    if (overrun_err !== 1'b0) begin n_bad++; $display("FAIL period_no_overrun: got %b want 0", overrun_err); end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    enable_mask = 6'b111111;
    period_cycles = 32'd50;
    done_delay = 12;
    spi_enable = 1'b1;
    wait_count(32'd1, 2000, ok);
    n_cmp++;
    if (!ok || overrun_err !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL overrun_set: err=%b busy=%b ok=%b want 1/0/1", overrun_err, busy, ok);
    end
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL overrun_restart: busy=%b want 1", busy); end
    clear_errors = 1'b1;
    @(negedge clock);
    clear_errors = 1'b0;
    n_cmp++;
    if (overrun_err !== 1'b0) begin n_bad++; $display("FAIL overrun_clear: got %b want 0", overrun_err); end
    spi_enable = 1'b0;
    wait_idle(300, ok);
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    enable_mask = 6'b111111;
    mute_en = 1'b1;
    mute_motor = 3;
    spi_enable = 1'b1;
    wait_count(32'd1, 1000, ok);
    spi_enable = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (!ok || timeout_err !== 1'b1 || timeout_motor !== 8'd3) begin
      n_bad++; $display("FAIL timeout_flag: err=%b motor=%0d want 1/3", timeout_err, timeout_motor);
    end
    n_cmp++;
    if (enc(lat_log) !== 64'hF01245 || enc(fs_log) !== 64'hF012345) begin
      n_bad++; $display("FAIL timeout_latches: lat=%h fs=%h want F01245/F012345", enc(lat_log), enc(fs_log));
    end
    clear_errors = 1'b1;
    @(negedge clock);
    clear_errors = 1'b0;
    n_cmp++;
    if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    do_reset();
    enable_mask = 6'b111111;
    spi_enable = 1'b1;
    wait_frames(3, 500, ok);
    repeat (3) @(negedge clock);
    spi_enable = 1'b0;
    wait_idle(200, ok);
    n_cmp++;
    if (!ok || enc(pid_log) !== 64'hF012) begin
      n_bad++; $display("FAIL drop_pid: got %h want F012 (ok=%b)", enc(pid_log), ok);
    end
    repeat (30) @(negedge clock);
    n_cmp++;
    if (enc(fs_log) !== 64'hF012 || cycle_count !== 32'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL drop_quiet: fs=%h count=%0d busy=%b want F012/0/0", enc(fs_log), cycle_count, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    enable_mask = 6'b000001;
    mute_en = 1'b1;
    mute_motor = 0;
    spi_enable = 1'b1;
    wait_frames(1, 100, ok);
    repeat (3) @(negedge clock);
    n_cmp++;
    if (!ok || ss_sel !== 6'b000001) begin
      n_bad++; $display("FAIL midreset_pre: ss_sel=%b want 000001 (ok=%b)", ss_sel, ok);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, frame_start, latch_strobe, pid_update} !== 4'd0 || ss_sel !== 6'd0 || motor_sel !== 8'd0) begin
      n_bad++; $display("FAIL midreset_async: flags=%b ss=%b motor=%0d want 0",
        {busy, frame_start, latch_strobe, pid_update}, ss_sel, motor_sel);
    end
    spi_enable = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    n_cmp++;
    if (lat_log.size() != 0 || pid_log.size() != 0) begin
      n_bad++; $display("FAIL midreset_no_latch: latches=%0d pids=%0d want 0", lat_log.size(), pid_log.size());
    end
  endtask

  task automatic test_stray_done();
    do_reset();
    enable_mask = 6'b111111;
    frame_done = 1'b1;
    @(negedge clock);
    frame_done = 1'b0;
    repeat (5) @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || lat_log.size() != 0) begin
      n_bad++; $display("FAIL stray_done: busy=%b latches=%0d want 0/0", busy, lat_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_period();
    test_overrun();
    test_timeout();
    test_enable_drop();
    test_reset_mid_frame();
    test_stray_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
